// File: rtl/osnt_reg_arb_pkg.sv
// osnt_reg_arb_pkg: FSM states, AXI response codes and timeout width shared by osnt_reg_access_arbiter.
package osnt_reg_arb_pkg;
   typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, DONE} state_e;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam int TMO_W = 8;
endpackage

// File: rtl/osnt_reg_access_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, search starts one past last_grant_i.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_grant_i,
   output logic [N-1:0]  gnt_oh_o,
   output logic [IW-1:0] gnt_idx_o
);
   logic [IW:0] pos;
   logic        found;
   always_comb begin
      gnt_idx_o = '0;
      found = 1'b0;
      pos = '0;
      for (int k = 1; k <= N; k++) begin
         pos = {1'b0, last_grant_i} + (IW+1)'(k);
         pos = pos >= (IW+1)'(N) ? pos - (IW+1)'(N) : pos;
         if (!found && req_i[pos[IW-1:0]]) begin
            found = 1'b1;
            gnt_idx_o = pos[IW-1:0];
         end
      end
      gnt_oh_o = found ? N'(1) << gnt_idx_o : '0;
   end
endmodule

// File: rtl/osnt_reg_access_arbiter.sv
// osnt_reg_access_arbiter: round-robin share of one AXI4-Lite master among NUM_REQ requesters.
// Define ARB_TIMEOUT_EN to build the per-transaction response timeout (SLVERR on expiry).
module osnt_reg_access_arbiter
   import osnt_reg_arb_pkg::*;
#(
   parameter int NUM_REQ            = 4,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_TIMEOUT_CYCLES   = 255
) (
   input  logic                                  axi_aclk,
   input  logic                                  axi_reset,
   input  logic [NUM_REQ-1:0]                    req_valid,
   input  logic [NUM_REQ-1:0]                    req_rnw,
   input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*C_M_AXI_DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]                    req_ack,
   output logic [C_M_AXI_DATA_WIDTH-1:0]         req_rdata,
   output logic [1:0]                            req_resp,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]         m_axi_awaddr,
   output logic                                  m_axi_awvalid,
   input  logic                                  m_axi_awready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]         m_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]       m_axi_wstrb,
   output logic                                  m_axi_wvalid,
   input  logic                                  m_axi_wready,
   input  logic [1:0]                            m_axi_bresp,
   input  logic                                  m_axi_bvalid,
   output logic                                  m_axi_bready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]         m_axi_araddr,
   output logic                                  m_axi_arvalid,
   input  logic                                  m_axi_arready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]         m_axi_rdata,
   input  logic [1:0]                            m_axi_rresp,
   input  logic                                  m_axi_rvalid,
   output logic                                  m_axi_rready
);
   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int DW = C_M_AXI_DATA_WIDTH;
   localparam int IW = $clog2(NUM_REQ);
   if (NUM_REQ < 2 || NUM_REQ > 8 || C_TIMEOUT_CYCLES < 1 || C_TIMEOUT_CYCLES >= 2**TMO_W) begin : g_bad_param
      $error("osnt_reg_access_arbiter: parameter out of range");
   end
   state_e            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d, last_q, last_d, arb_idx;
   logic [NUM_REQ-1:0] oh_q, oh_d, arb_oh, ack_q;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
   logic [1:0]        resp_q, resp_d;
   logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
   logic              tmo;
   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req_i        (req_valid),
      .last_grant_i (last_q),
      .gnt_oh_o     (arb_oh),
      .gnt_idx_o    (arb_idx)
   );
`ifdef ARB_TIMEOUT_EN
   logic             busy;
   logic [TMO_W-1:0] cnt_q;
   assign busy = state_q != IDLE && state_q != DONE;
   always_ff @(posedge axi_aclk) begin
      cnt_q <= axi_reset || !busy ? '0 : cnt_q + 1'b1;
   end
   assign tmo = busy && cnt_q == TMO_W'(C_TIMEOUT_CYCLES);
`else
   assign tmo = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      oh_d = oh_q;
      last_d = last_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      resp_d = resp_q;
      aw_done_d = aw_done_q | (awvalid_q & m_axi_awready);
      w_done_d = w_done_q | (wvalid_q & m_axi_wready);
      if (tmo) begin
         state_d = DONE;
         rdata_d = '0;
         resp_d = SLVERR;
      end else begin
         case (state_q)
            IDLE: if (|req_valid) begin
               idx_d = arb_idx;
               oh_d = arb_oh;
               addr_d = req_addr[int'(arb_idx)*AW +: AW];
               wdata_d = req_wdata[int'(arb_idx)*DW +: DW];
               rdata_d = '0;
               resp_d = OKAY;
               aw_done_d = 1'b0;
               w_done_d = 1'b0;
               state_d = req_rnw[arb_idx] ? RD_AR : WR_AW_W;
            end
            WR_AW_W: state_d = aw_done_d && w_done_d ? WR_B : WR_AW_W;
            WR_B: if (m_axi_bvalid) begin
               resp_d = m_axi_bresp;
               state_d = DONE;
            end
            RD_AR: state_d = m_axi_arready ? RD_R : RD_AR;
            RD_R: if (m_axi_rvalid) begin
               rdata_d = m_axi_rdata;
               resp_d = m_axi_rresp;
               state_d = DONE;
            end
            DONE: begin
               last_d = idx_q;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end
   // Output flops are loaded from next-state so every AXI/requester output is registered.
   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         state_q <= IDLE;
         idx_q <= '0;
         oh_q <= '0;
         last_q <= IW'(NUM_REQ-1);
         addr_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         resp_q <= OKAY;
         aw_done_q <= 1'b0;
         w_done_q <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q <= 1'b0;
         bready_q <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q <= 1'b0;
         ack_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         oh_q <= oh_d;
         last_q <= last_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         resp_q <= resp_d;
         aw_done_q <= aw_done_d;
         w_done_q <= w_done_d;
         awvalid_q <= state_d == WR_AW_W && !aw_done_d;
         wvalid_q <= state_d == WR_AW_W && !w_done_d;
         bready_q <= state_d == WR_B;
         arvalid_q <= state_d == RD_AR;
         rready_q <= state_d == RD_R;
         ack_q <= state_d == DONE ? oh_d : '0;
      end
   end
   assign req_ack = ack_q;
   assign req_rdata = rdata_q;
   assign req_resp = resp_q;
   assign m_axi_awaddr = addr_q;
   assign m_axi_araddr = addr_q;
   assign m_axi_wdata = wdata_q;
   assign m_axi_wstrb = '1;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wvalid = wvalid_q;
   assign m_axi_bready = bready_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready = rready_q;
endmodule

// File: tb/tb_osnt_reg_access_arbiter.sv
// tb_osnt_reg_access_arbiter: directed vectors against a latency-configurable AXI4-Lite slave model.
module tb_osnt_reg_access_arbiter;
   logic clk = 1'b0, rst = 1'b1;
   logic [3:0] req_valid = '0, req_rnw = '0, req_ack;
   logic [127:0] req_addr = '0, req_wdata = '0;
   logic [31:0] req_rdata, m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
   logic [3:0] m_axi_wstrb;
   logic [1:0] req_resp, m_axi_bresp, m_axi_rresp;
   logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
   logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
   always #5 clk = ~clk;
   osnt_reg_access_arbiter #(.NUM_REQ(4), .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(32), .C_TIMEOUT_CYCLES(20)) dut (
      .axi_aclk(clk), .axi_reset(rst), .req_valid(req_valid), .req_rnw(req_rnw), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ack(req_ack), .req_rdata(req_rdata), .req_resp(req_resp),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );
   // Slave model: each ready/valid appears after a configurable number of wait cycles.
   int s_aw_lat = 0, s_w_lat = 0, s_b_lat = 0, s_ar_lat = 0, s_r_lat = 0;
   logic [31:0] s_rdata = '0;
   logic [1:0] s_resp = '0;
   int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, b_hs = 0;
   logic aw_got, w_got, b_pend, r_pend, aw_n, w_n;
   logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
   logic [3:0] cap_wstrb;
   assign m_axi_awready = m_axi_awvalid && aw_cnt >= s_aw_lat;
   assign m_axi_wready = m_axi_wvalid && w_cnt >= s_w_lat;
   assign m_axi_arready = m_axi_arvalid && ar_cnt >= s_ar_lat;
   assign m_axi_bvalid = b_pend && b_cnt >= s_b_lat;
   assign m_axi_rvalid = r_pend && r_cnt >= s_r_lat;
   assign m_axi_bresp = s_resp;
   assign m_axi_rresp = s_resp;
   assign m_axi_rdata = s_rdata;
   assign aw_n = aw_got | (m_axi_awvalid & m_axi_awready);
   assign w_n = w_got | (m_axi_wvalid & m_axi_wready);
   always @(posedge clk) begin
      if (rst) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
         aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
      end else begin
         aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
         w_cnt <= (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
         ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
         if (m_axi_awvalid && m_axi_awready) cap_awaddr <= m_axi_awaddr;
         if (m_axi_wvalid && m_axi_wready) begin cap_wdata <= m_axi_wdata; cap_wstrb <= m_axi_wstrb; end
         if (aw_n && w_n) begin b_pend <= 1; b_cnt <= 0; aw_got <= 0; w_got <= 0; end
         else begin aw_got <= aw_n; w_got <= w_n; end
         if (b_pend) begin
            if (m_axi_bvalid && m_axi_bready) begin b_pend <= 0; b_hs <= b_hs + 1; end
            else b_cnt <= b_cnt + 1;
         end
         if (m_axi_arvalid && m_axi_arready) begin cap_araddr <= m_axi_araddr; r_pend <= 1; r_cnt <= 0; end
         if (r_pend) begin
            if (m_axi_rvalid && m_axi_rready) r_pend <= 0;
            else r_cnt <= r_cnt + 1;
         end
      end
   end
   int n_chk = 0, n_pass = 0;
   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask
   task automatic set_slot(input int i, input bit rnw, input logic [31:0] a, input logic [31:0] d);
      req_rnw[i] = rnw;
      req_addr[i*32 +: 32] = a;
      req_wdata[i*32 +: 32] = d;
   endtask
   function automatic int oh2i(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction
   task automatic step();
      @(posedge clk); #1;
   endtask
   typedef struct {
      int req; bit rnw; logic [31:0] addr, wdata, sdata; logic [1:0] sresp;
      int aw_lat, w_lat, b_lat, ar_lat, r_lat; bit drop, hs;
      int exp_lat; logic [31:0] exp_rdata; logic [1:0] exp_resp;
   } vec_t;
   vec_t vecs[6];
   task automatic run_vec(input vec_t v);
      int lat, b0;
      logic [3:0] ack;
      s_aw_lat = v.aw_lat; s_w_lat = v.w_lat; s_b_lat = v.b_lat; s_ar_lat = v.ar_lat; s_r_lat = v.r_lat;
      s_rdata = v.sdata; s_resp = v.sresp; b0 = b_hs;
      for (int i = 0; i < 4; i++) set_slot(i, ~v.rnw, 32'hBAD0_0000 | i, 32'h5A5A_0000 | i);
      set_slot(v.req, v.rnw, v.addr, v.wdata);
      req_valid = 4'(1) << v.req;
      step();
      set_slot(v.req, ~v.rnw, ~v.addr, ~v.wdata);
      if (v.drop) req_valid = '0;
      lat = 1;
      while (req_ack == '0 && lat < 40) begin step(); lat++; end
      ack = req_ack;
      req_valid = '0;
      chk("latency", lat, v.exp_lat);
      chk("ack_onehot", ack, 4'(1) << v.req);
      chk("rdata", req_rdata, v.exp_rdata);
      chk("resp", req_resp, v.exp_resp);
      chk("axi_idle_at_ack", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
      if (v.hs) chk("addr", v.rnw ? cap_araddr : cap_awaddr, v.addr);
      if (!v.rnw) begin
         chk("wdata", cap_wdata, v.wdata);
         chk("wstrb", cap_wstrb, 4'hF);
         chk("b_handshakes", b_hs - b0, 1);
      end
      step();
      chk("ack_one_cycle", req_ack, 0);
   endtask
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int c, ord[6], acks;
      logic aw[7], w[7], br[7], ak[7];
      vec_t tv;
      vecs[0] = '{req:0, rnw:0, addr:32'h10, wdata:32'hDEADBEEF, sdata:32'h0, sresp:2'b00, aw_lat:0, w_lat:0, b_lat:0, ar_lat:0, r_lat:0, drop:0, hs:1, exp_lat:3, exp_rdata:32'h0, exp_resp:2'b00};
      vecs[1] = '{req:2, rnw:1, addr:32'h08, wdata:32'h0, sdata:32'h12345678, sresp:2'b00, aw_lat:0, w_lat:0, b_lat:0, ar_lat:0, r_lat:2, drop:0, hs:1, exp_lat:5, exp_rdata:32'h12345678, exp_resp:2'b00};
      vecs[2] = '{req:1, rnw:0, addr:32'h24, wdata:32'h0BADCAFE, sdata:32'h0, sresp:2'b10, aw_lat:0, w_lat:0, b_lat:1, ar_lat:0, r_lat:0, drop:0, hs:1, exp_lat:4, exp_rdata:32'h0, exp_resp:2'b10};
      vecs[3] = '{req:3, rnw:1, addr:32'h3C, wdata:32'h0, sdata:32'hA5A5A5A5, sresp:2'b00, aw_lat:0, w_lat:0, b_lat:0, ar_lat:2, r_lat:0, drop:1, hs:1, exp_lat:5, exp_rdata:32'hA5A5A5A5, exp_resp:2'b00};
      vecs[4] = '{req:1, rnw:0, addr:32'h40, wdata:32'h11223344, sdata:32'h0, sresp:2'b00, aw_lat:2, w_lat:0, b_lat:0, ar_lat:0, r_lat:0, drop:0, hs:1, exp_lat:5, exp_rdata:32'h0, exp_resp:2'b00};
      vecs[5] = '{req:0, rnw:1, addr:32'h7C, wdata:32'h0, sdata:32'hCAFEF00D, sresp:2'b01, aw_lat:0, w_lat:0, b_lat:0, ar_lat:0, r_lat:0, drop:0, hs:1, exp_lat:3, exp_rdata:32'hCAFEF00D, exp_resp:2'b01};
      repeat (3) step();
      chk("reset_ctrl", {req_ack, req_resp, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
      chk("reset_data", req_rdata | m_axi_awaddr | m_axi_araddr | m_axi_wdata, 0);
      chk("reset_wstrb", m_axi_wstrb, 4'hF);
      rst = 1'b0;
      step();
      for (int i = 0; i < 6; i++) run_vec(vecs[i]);
      // split write: wready three cycles after awready
      s_aw_lat = 0; s_w_lat = 3; s_b_lat = 0; s_resp = 2'b00; c = b_hs;
      set_slot(0, 0, 32'h60, 32'h600D_F00D);
      req_valid = 4'b0001;
      for (int i = 1; i <= 6; i++) begin
         step();
         aw[i] = m_axi_awvalid; w[i] = m_axi_wvalid; br[i] = m_axi_bready; ak[i] = req_ack[0];
      end
      req_valid = '0;
      chk("split_aw_c1", {aw[1], w[1]}, 2'b11);
      chk("split_aw_drop_c2", {aw[2], w[2]}, 2'b01);
      chk("split_w_held_c4", w[4], 1);
      chk("split_b_c5", {w[5], br[5], ak[5]}, 3'b010);
      chk("split_ack_c6", ak[6], 1);
      chk("split_b_count", b_hs - c, 1);
      chk("split_wdata", cap_wdata, 32'h600D_F00D);
      step();
      // fairness from reset: everybody asks all the time
      rst = 1'b1; step(); rst = 1'b0;
      s_w_lat = 0;
      for (int i = 0; i < 4; i++) set_slot(i, 0, 32'h100 + 32'(i), 32'hF000 + 32'(i));
      req_valid = 4'hF;
      for (int n = 0; n < 6; n++) begin
         c = 0;
         do begin step(); c++; end while (req_ack == '0 && c < 20);
         ord[n] = oh2i(req_ack);
      end
      req_valid = '0;
      chk("fair_0", ord[0], 0); chk("fair_1", ord[1], 1); chk("fair_2", ord[2], 2);
      chk("fair_3", ord[3], 3); chk("fair_4", ord[4], 0); chk("fair_5", ord[5], 1);
      step();
      req_valid = 4'b0100;
      for (int n = 0; n < 3; n++) begin
         c = 0;
         do begin step(); c++; end while (req_ack == '0 && c < 20);
         chk("single_hog", oh2i(req_ack), 2);
      end
      req_valid = '0;
      step();
`ifdef ARB_TIMEOUT_EN
      tv = vecs[1];
      tv.req = 1; tv.addr = 32'h50; tv.sdata = 32'hFFFFFFFF; tv.ar_lat = 1000; tv.r_lat = 0;
      tv.hs = 0; tv.exp_lat = 22; tv.exp_rdata = 32'h0; tv.exp_resp = 2'b10;
      run_vec(tv);
      run_vec(vecs[1]);
`else
      tv = vecs[2];
      tv.req = 3; tv.addr = 32'h54;
      run_vec(tv);
`endif
      // reset while waiting on B
      s_aw_lat = 0; s_w_lat = 0; s_b_lat = 4;
      set_slot(1, 0, 32'h70, 32'h7777_7777);
      req_valid = 4'b0010;
      step(); step();
      chk("midrst_in_wr_b", m_axi_bready, 1);
      rst = 1'b1; req_valid = '0;
      step();
      rst = 1'b0;
      chk("midrst_ctrl", {req_ack, req_resp, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
      chk("midrst_data", req_rdata | m_axi_awaddr | m_axi_araddr | m_axi_wdata, 0);
      acks = 0;
      for (int i = 0; i < 6; i++) begin step(); if (req_ack != '0) acks++; end
      chk("midrst_no_ack", acks, 0);
      run_vec(vecs[0]);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
